sdm_sample_sched: RTL and testbench
===================================

Name: sdm_sample_sched

Overview:
Sample scheduler and buffer that sits in front of the first-order SDM (SDM1st) and drives its din bus.
- Accepts 16-bit samples from an upstream source via a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample to the modulator every OSR clocks.
- Handles start-up priming, underrun and enable/disable sequencing, so the modulator always sees a well-defined din.

Parameters:
N, 16, sample width (matches SDM din width)
DEPTH, 8, FIFO depth in samples; power of 2, at least 2
OSR, 2, clocks per output sample (clk 50 MHz, OSR 2 gives 25 MS/s); at least 2
PRIME_LVL, 4, FIFO fill required before playback starts; 1 to DEPTH

Ports:
clk  in  1  system clock, rising edge
areset  in  1  asynchronous active-low reset
enable  in  1  playback enable; level-sensitive
s_valid  in  1  upstream sample valid
s_ready  out  1  scheduler can accept a sample
s_data  in  N  upstream sample
din  out  N  sample to SDM din; registered
samp_tick  out  1  one-cycle pulse, high in the first cycle a new din is presented
underrun  out  1  sticky underrun flag
clr_underrun  in  1  synchronous clear of underrun
fill  out  $clog2(DEPTH)+1  current FIFO occupancy
state  out  2  FSM state: 0 IDLE, 1 PRIME, 2 RUN

Behaviour:
- Reset (areset low, asynchronous) forces: din=0, samp_tick=0, underrun=0, fill=0, state=IDLE, divider cnt=0, FIFO pointers=0.
- Push:
  - s_ready = (fill != DEPTH) and enable, combinational from registered fill.
  - A push occurs on an edge where s_valid and s_ready are both high.
  - s_data is written at the write pointer, which wraps modulo DEPTH.
- Pop: reads the head and advances the read pointer, modulo DEPTH.
- fill update on the same edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Push while full is impossible because s_ready is low.
- No empty-FIFO bypass: a push and a pop-attempt on the same edge with fill=0 counts as empty for the pop.
- Divider cnt:
  - Counts 0..OSR-1 only in RUN; held at 0 in IDLE and PRIME.
  - A tick edge is one where state=RUN and cnt=OSR-1.
- FSM:
  - IDLE:
    - din=0; FIFO flushed (pointers and fill held at 0).
    - enable=1 moves to PRIME on the next edge.
  - PRIME:
    - din holds its current value; pushes accepted.
    - fill >= PRIME_LVL moves to RUN with cnt=0.
    - The first pop occurs OSR clocks after entering RUN.
  - RUN, on a tick edge with fill > 0:
    - din <= head, pop, samp_tick <= 1, cnt <= 0.
  - RUN, on a tick edge with fill = 0:
    - underrun <= 1, din <= 0, samp_tick <= 1.
    - Next state is PRIME.
  - Any state with enable=0:
    - Next edge goes to IDLE; din <= 0, FIFO flushed, cnt <= 0, samp_tick <= 0.
    - A push offered in that cycle is not accepted, since s_ready is low.
- samp_tick is high for exactly one cycle per tick edge and low otherwise.
- underrun:
  - Set on an underrun tick; cleared by clr_underrun.
  - Set wins if both occur on the same edge.
  - Not cleared by enable=0.
- Reset asserted mid-operation discards buffered data; din returns to 0 immediately.

Optional Feature:
SDM_SCHED_HOLD_EN
- Defined: on an underrun tick, din keeps its previous value (no zero insertion), underrun is still set and samp_tick still pulses. State stays RUN, and playback resumes on the next tick with data.
- Undefined: zero insertion and a return to PRIME, as above.

Test Plan (OSR=2, DEPTH=8, PRIME_LVL=4):
- Reset then enable=1, push 0x0001..0x0003 (3 samples) -> state stays PRIME, din=0, no samp_tick, fill=3.
- Push a 4th sample 0x0004 -> RUN next edge; din=0x0001 visible 2 clocks later with samp_tick, then 0x0002/0x0003/0x0004 every 2 clocks.
- Continuous push of 8 samples with enable=1 and playback stalled in PRIME (PRIME_LVL set to 8) -> fill=8, s_ready=0, the 9th s_valid is not accepted, and the first 8 values play in order after wrap.
- Let the FIFO drain -> on the tick after the last sample: underrun=1, din=0x0000, state=PRIME. clr_underrun then gives underrun=0. Under SDM_SCHED_HOLD_EN instead: din holds the last value and state stays RUN.
- Drop enable mid-RUN with fill=5 -> next edge state=IDLE, din=0, fill=0, s_ready=0; re-enable then requires re-priming.
- Pulse areset low for one half-cycle mid-RUN -> outputs go to reset values asynchronously, and the FSM restarts from IDLE.

Source files
------------

// File: rtl/sdm_sample_sched.sv
// sdm_sample_sched
//   Sample scheduler and buffer feeding the din bus of a first-order SDM.
//   Upstream samples arrive over a valid/ready handshake into a DEPTH-entry
//   FIFO; once PRIME_LVL samples are buffered, one sample is released to din
//   every OSR clocks. An empty FIFO at release time raises a sticky underrun.
//
//   Optional build macro SDM_SCHED_HOLD_EN:
//     defined   - an underrun tick keeps the previous din and stays in RUN
//     undefined - an underrun tick drives din to zero and returns to PRIME
//
// Ports
//   clk          system clock, rising edge
//   areset       asynchronous active-low reset
//   enable       playback enable (level); low flushes the FIFO and idles
//   s_valid      upstream sample valid
//   s_ready      scheduler can accept a sample
//   s_data       upstream sample
//   din          registered sample to the modulator
//   samp_tick    one-cycle pulse in the first cycle a new din is presented
//   underrun     sticky underrun flag
//   clr_underrun synchronous clear of underrun (a same-edge set wins)
//   fill         current FIFO occupancy
//   state        FSM state: 0 IDLE, 1 PRIME, 2 RUN

module sdm_sample_sched #(
    parameter int N         = 16,
    parameter int DEPTH     = 8,
    parameter int OSR       = 2,
    parameter int PRIME_LVL = 4
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    enable,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [N-1:0]            s_data,
    output logic [N-1:0]            din,
    output logic                    samp_tick,
    output logic                    underrun,
    input  logic                    clr_underrun,
    output logic [$clog2(DEPTH):0]  fill,
    output logic [1:0]              state
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int CW = $clog2(OSR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [N-1:0]    din_d;
    logic            tick_d;
    logic            und_d;
    logic [N-1:0]    mem [DEPTH];

    logic            push;
    logic            pop;
    logic            tick;
    logic            empty;

    assign fill    = fill_q;
    assign state   = state_q;
    assign s_ready = (fill_q != FW'(DEPTH)) && enable;
    assign push    = s_valid && s_ready;
    assign empty   = (fill_q == '0);
    // A release edge: only in RUN, only while enabled (disable overrides it).
    assign tick    = enable && (state_q == RUN) && (cnt_q == CW'(OSR - 1));
    // Occupancy is the registered value, so a same-edge push never bypasses
    // into an empty FIFO.
    assign pop     = tick && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        fill_d  = fill_q;
        din_d   = din;
        tick_d  = tick;
        und_d   = underrun;

        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase

        if (tick && empty) begin
            und_d = 1'b1;
        end else if (clr_underrun) begin
            und_d = 1'b0;
        end

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            fill_d  = '0;
            din_d   = '0;
        end else begin
            case (state_q)
                // The FIFO is already empty here (disable flushed it), and a
                // push completing its handshake on the IDLE->PRIME edge is kept.
                IDLE: begin
                    state_d = PRIME;
                    cnt_d   = '0;
                    din_d   = '0;
                end
                PRIME: begin
                    cnt_d = '0;
                    if (fill_q >= FW'(PRIME_LVL)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        cnt_d = '0;
                        if (!empty) begin
                            din_d = mem[rptr_q];
                        end else begin
`ifdef SDM_SCHED_HOLD_EN
                            din_d = din;
`else
                            din_d   = '0;
                            state_d = PRIME;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    din_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            fill_q    <= '0;
            din       <= '0;
            samp_tick <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            fill_q    <= fill_d;
            din       <= din_d;
            samp_tick <= tick_d;
            underrun  <= und_d;
        end
    end

endmodule

// File: tb/tb_sdm_sample_sched.sv
module tb_sdm_sample_sched;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        clr_underrun = 1'b0;

    logic        s_ready, samp_tick, underrun;
    logic [15:0] din;
    logic [3:0]  fill;
    logic [1:0]  state;

    logic        f_ready, f_tick, f_und;
    logic [15:0] f_din;
    logic [3:0]  f_fill;
    logic [1:0]  f_state;

`ifdef SDM_SCHED_HOLD_EN
    localparam bit H = 1'b1;
`else
    localparam bit H = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdm_sample_sched #(.N(16), .DEPTH(8), .OSR(2), .PRIME_LVL(4)) u_dut (
        .clk(clk), .areset(areset), .enable(enable), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .din(din), .samp_tick(samp_tick),
        .underrun(underrun), .clr_underrun(clr_underrun), .fill(fill), .state(state)
    );

    // Same stimulus, but priming needs a full FIFO so it can be filled while stalled.
    sdm_sample_sched #(.N(16), .DEPTH(8), .OSR(2), .PRIME_LVL(8)) u_full (
        .clk(clk), .areset(areset), .enable(enable), .s_valid(s_valid),
        .s_ready(f_ready), .s_data(s_data), .din(f_din), .samp_tick(f_tick),
        .underrun(f_und), .clr_underrun(clr_underrun), .fill(f_fill), .state(f_state)
    );

    typedef struct {
        logic        en;
        logic        vld;
        logic [15:0] data;
        logic        clr;
        logic [15:0] e_din;
        logic        e_tick;
        logic        e_und;
        logic [3:0]  e_fill;
        logic [1:0]  e_state;
        logic        e_ready;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic en, input logic vld, input logic [15:0] data,
                                input logic clr, input logic [15:0] e_din, input logic e_tick,
                                input logic e_und, input logic [3:0] e_fill,
                                input logic [1:0] e_state);
        vec_t v;
        v.en = en; v.vld = vld; v.data = data; v.clr = clr;
        v.e_din = e_din; v.e_tick = e_tick; v.e_und = e_und;
        v.e_fill = e_fill; v.e_state = e_state;
        v.e_ready = en && (e_fill != 4'd8);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic v, input logic [15:0] d, input logic c);
        enable = e; s_valid = v; s_data = d; clr_underrun = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0; s_valid = 1'b0; clr_underrun = 1'b0;
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        areset = 1'b1;
    endtask

    int got;

    initial begin
        // Reset state
        #12;
        chk("rst_din", din, 0);
        chk("rst_tick", samp_tick, 0);
        chk("rst_und", underrun, 0);
        chk("rst_fill", fill, 0);
        chk("rst_state", state, 0);
        chk("rst_ready", s_ready, 0);
        @(negedge clk);
        areset = 1'b1;

        tbl[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 1);
        tbl[1]  = mk(1, 1, 16'h0001, 0, 16'h0000, 0, 0, 1, 1);
        tbl[2]  = mk(1, 1, 16'h0002, 0, 16'h0000, 0, 0, 2, 1);
        tbl[3]  = mk(1, 1, 16'h0003, 0, 16'h0000, 0, 0, 3, 1);
        tbl[4]  = mk(1, 1, 16'h0004, 0, 16'h0000, 0, 0, 4, 1);
        tbl[5]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 4, 2);
        tbl[6]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 4, 2);
        tbl[7]  = mk(1, 0, 16'h0000, 0, 16'h0001, 1, 0, 3, 2);
        tbl[8]  = mk(1, 0, 16'h0000, 0, 16'h0001, 0, 0, 3, 2);
        tbl[9]  = mk(1, 0, 16'h0000, 0, 16'h0002, 1, 0, 2, 2);
        tbl[10] = mk(1, 0, 16'h0000, 0, 16'h0002, 0, 0, 2, 2);
        tbl[11] = mk(1, 0, 16'h0000, 0, 16'h0003, 1, 0, 1, 2);
        tbl[12] = mk(1, 0, 16'h0000, 0, 16'h0003, 0, 0, 1, 2);
        tbl[13] = mk(1, 0, 16'h0000, 0, 16'h0004, 1, 0, 0, 2);
        tbl[14] = mk(1, 0, 16'h0000, 0, 16'h0004, 0, 0, 0, 2);
        tbl[15] = mk(1, 0, 16'h0000, 0, H ? 16'h0004 : 16'h0000, 1, 1, 0, H ? 2'd2 : 2'd1);
        tbl[16] = mk(1, 0, 16'h0000, 0, H ? 16'h0004 : 16'h0000, 0, 1, 0, H ? 2'd2 : 2'd1);
        tbl[17] = mk(1, 1, 16'h0005, 1, H ? 16'h0004 : 16'h0000, H, H, 1, H ? 2'd2 : 2'd1);
        tbl[18] = mk(1, 0, 16'h0000, 0, H ? 16'h0004 : 16'h0000, 0, H, 1, H ? 2'd2 : 2'd1);
        tbl[19] = mk(1, 0, 16'h0000, 0, H ? 16'h0005 : 16'h0000, H, H, H ? 4'd0 : 4'd1, H ? 2'd2 : 2'd1);
        tbl[20] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, H, 0, 0);
        tbl[21] = mk(0, 0, 16'h0000, 1, 16'h0000, 0, 0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].en, tbl[i].vld, tbl[i].data, tbl[i].clr);
            chk($sformatf("v%0d_din", i), din, tbl[i].e_din);
            chk($sformatf("v%0d_tick", i), samp_tick, tbl[i].e_tick);
            chk($sformatf("v%0d_und", i), underrun, tbl[i].e_und);
            chk($sformatf("v%0d_fill", i), fill, tbl[i].e_fill);
            chk($sformatf("v%0d_state", i), state, tbl[i].e_state);
            chk($sformatf("v%0d_ready", i), s_ready, tbl[i].e_ready);
        end

        // Drain to underrun with clr_underrun on the same edge: set wins.
        step(1, 0, 16'h0000, 0);
        for (int k = 0; k < 4; k++) step(1, 1, 16'h0021 + 16'(k), 0);
        got = 0;
        for (int i = 0; i < 30; i++) begin
            if (got == 4) break;
            step(1, 0, 16'h0000, 0);
            if (samp_tick) begin
                chk($sformatf("drain_val%0d", got), din, 16'h0021 + got);
                got++;
            end
        end
        chk("drain_tick_count", got, 4);
        step(1, 0, 16'h0000, 0);
        chk("drain_pre_und", underrun, 0);
        chk("drain_pre_tick", samp_tick, 0);
        step(1, 0, 16'h0000, 1);
        chk("ur_setwins_und", underrun, 1);
        chk("ur_tick", samp_tick, 1);
        chk("ur_din", din, H ? 16'h0024 : 16'h0000);
        chk("ur_state", state, H ? 2 : 1);
        step(0, 0, 16'h0000, 0);
        chk("ur_sticky_disable", underrun, 1);
        chk("ur_disable_state", state, 0);
        step(0, 0, 16'h0000, 1);
        chk("ur_clear", underrun, 0);

        // Disable mid-RUN with fill=5.
        step(1, 0, 16'h0000, 0);
        for (int k = 0; k < 4; k++) step(1, 1, 16'h0031 + 16'(k), 0);
        step(1, 1, 16'h0035, 0);
        chk("dis_enter_run", state, 2);
        chk("dis_fill5", fill, 5);
        step(1, 1, 16'h0036, 0);
        step(1, 0, 16'h0000, 0);
        chk("dis_first_din", din, 16'h0031);
        chk("dis_fill_pre", fill, 5);
        step(0, 1, 16'h0037, 0);
        chk("dis_state", state, 0);
        chk("dis_din", din, 0);
        chk("dis_fill", fill, 0);
        chk("dis_ready", s_ready, 0);
        chk("dis_tick", samp_tick, 0);
        step(1, 0, 16'h0000, 0);
        step(1, 1, 16'h0040, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 16'h0000, 0);
        chk("reprime_state", state, 1);
        chk("reprime_fill", fill, 1);
        chk("reprime_din", din, 0);

        // Fill to DEPTH while stalled in PRIME, refuse the 9th, play in order.
        do_reset();
        step(1, 0, 16'h0000, 0);
        for (int k = 0; k < 8; k++) step(1, 1, 16'h0010 + 16'(k), 0);
        chk("full_fill", f_fill, 8);
        chk("full_ready", f_ready, 0);
        chk("full_state_prime", f_state, 1);
        step(1, 1, 16'h0099, 0);
        chk("full_9th_refused", f_fill, 8);
        chk("full_state_run", f_state, 2);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (got == 8) break;
            step(1, 0, 16'h0000, 0);
            if (f_tick) begin
                chk($sformatf("full_val%0d", got), f_din, 16'h0010 + got);
                got++;
            end
        end
        chk("full_tick_count", got, 8);

        // Asynchronous reset pulse mid-RUN.
        do_reset();
        step(1, 0, 16'h0000, 0);
        for (int k = 0; k < 4; k++) step(1, 1, 16'h0051 + 16'(k), 0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 16'h0000, 0);
            if (samp_tick) begin
                got = 1;
                break;
            end
        end
        chk("ar_first_tick_seen", got, 1);
        chk("ar_pre_din", din, 16'h0051);
        #1 areset = 1'b0;
        #1;
        chk("ar_din", din, 0);
        chk("ar_state", state, 0);
        chk("ar_fill", fill, 0);
        chk("ar_tick", samp_tick, 0);
        #2 areset = 1'b1;
        step(1, 0, 16'h0000, 0);
        chk("ar_restart_state", state, 1);
        chk("ar_restart_fill", fill, 0);
        chk("ar_restart_din", din, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
